// File: rtl/lin_sched.sv
// lin_sched: round-robin arbiter that shares one linear layer among N_REQ requesters,
// measuring the runtime of each operation and giving up after TIMEOUT wait cycles.
module lin_sched #(
  parameter int N_REQ      = 2,
  parameter int OUT_DATA_W = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      gnt,
  output logic                  lin_start,
  input  logic                  lin_done,
  input  logic [OUT_DATA_W-1:0] lin_y,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [OUT_DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]      rsp_cycles,
  output logic                  rsp_timeout,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [IDW-1:0]        ptr_q, ptr_d, sel_q, sel_d, pick;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  done_dly_q, done_dly_d;
  logic                  lin_start_q, lin_start_d, rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]        rsp_id_q, rsp_id_d;
  logic [OUT_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]      rsp_cycles_q, rsp_cycles_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  found, done_edge;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = IDW'((int'(ptr_q) + i) % N_REQ);
      end
    end
    done_edge     = lin_done && !done_dly_q;
    cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    done_dly_d    = lin_done;
    lin_start_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_cycles_d  = rsp_cycles_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: if (found) begin
        state_d     = ISSUE;
        gnt_d       = '0;
        gnt_d[pick] = 1'b1;
        sel_d       = pick;
        ptr_d       = IDW'((int'(pick) + 1) % N_REQ);
        lin_start_d = 1'b1;
        cnt_d       = '0;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // a done edge wins over a timeout landing on the same cycle
        if (done_edge || cnt_inc >= CNT_W'(TIMEOUT)) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = sel_q;
          rsp_data_d    = done_edge ? lin_y : '0;
          rsp_cycles_d  = done_edge ? cnt_inc : CNT_W'(TIMEOUT);
          rsp_timeout_d = !done_edge;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      ptr_q         <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      done_dly_q    <= 1'b0;
      lin_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      done_dly_q    <= done_dly_d;
      lin_start_q   <= lin_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_cycles_q  <= rsp_cycles_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign lin_start   = lin_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_lin_sched.sv
// tb_lin_sched: randomized transaction-level check of lin_sched against a per-operation reference model.
module tb_lin_sched;
  logic       clk = 1'b0;
  logic       rst, lin_start, lin_done, rsp_valid, rsp_timeout, busy;
  logic [1:0] req, gnt;
  logic [3:0] lin_y, rsp_data;
  logic [0:0] rsp_id;
  logic [15:0] rsp_cycles;

  int         n_chk = 0, n_pass = 0, ptr_m = 0;
  logic       w [0:20];
  logic [3:0] yv [0:20];
  logic       pre;
  int         last_id, last_cyc;
  logic [3:0] last_data;
  logic       last_to;

  lin_sched #(.N_REQ(2), .OUT_DATA_W(4), .CNT_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .lin_start(lin_start),
    .lin_done(lin_done), .lin_y(lin_y), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag);
    chk({tag, "_id"}, 32'(rsp_id), 32'(last_id));
    chk({tag, "_data"}, 32'(rsp_data), 32'(last_data));
    chk({tag, "_cycles"}, 32'(rsp_cycles), 32'(last_cyc));
    chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(last_to));
  endtask

  // lin_done waveform per cycle k after lin_start (k=0 is the start cycle):
  // mode 0 clean rise at d; mode 1 stale-high dropping at lo and rising again at lo+d; mode 2 noise
  task automatic gen(input int mode, input int d, input int lo);
    pre = (mode == 1);
    for (int k = 0; k <= 20; k++) begin
      w[k]  = (mode == 0) ? (k >= d) : (mode == 1) ? (k < lo || k >= lo + d) : 1'($urandom);
      yv[k] = 4'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req = '0; lin_done = 1'($urandom); lin_y = 4'($urandom);
      tick();
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(rsp_valid), 0);
      chk("idle_start", 32'(lin_start), 0);
      chk_rsp("idle_hold");
    end
  endtask

  task automatic op(input logic [1:0] r, input int rst_at);
    int sel, ek, ek1;
    logic [1:0] g;
    req = r; lin_done = pre; lin_y = 4'($urandom);
    sel = r[ptr_m] ? ptr_m : 1 - ptr_m;
    g = 2'b01 << sel;
    tick();
    chk("grant", 32'(gnt), 32'(g));
    chk("start", 32'(lin_start), 1);
    chk("busy", 32'(busy), 1);
    chk("issue_valid", 32'(rsp_valid), 0);
    ptr_m = (sel + 1) % 2;
    // first rising edge of lin_done inside the wait window, if any
    ek = 0;
    for (int k = 1; k <= 16; k++) if (ek == 0 && w[k] && !w[k-1]) ek = k;
    ek1 = (ek != 0) ? ek + 1 : 17;
    for (int k = 0; k < ek1; k++) begin
      lin_done = w[k]; lin_y = yv[k]; req = 2'($urandom);
      rst = (k == rst_at);
      tick();
      if (rst) begin
        rst = 1'b0; ptr_m = 0;
        last_id = 0; last_data = '0; last_cyc = 0; last_to = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_start", 32'(lin_start), 0);
        chk_rsp("rst_rsp");
        return;
      end
      if (k + 1 < ek1) begin
        chk("wait_valid", 32'(rsp_valid), 0);
        chk("wait_gnt", 32'(gnt), 32'(g));
        chk("wait_start", 32'(lin_start), 0);
        chk("wait_busy", 32'(busy), 1);
      end
    end
    last_id = sel; last_data = (ek != 0) ? yv[ek] : 4'd0;
    last_cyc = (ek != 0) ? ek : 16; last_to = (ek == 0);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_gnt", 32'(gnt), 32'(g));
    chk("rsp_busy", 32'(busy), 1);
    chk_rsp("rsp");
    lin_done = 1'($urandom); req = 2'($urandom);
    tick();
    chk("after_valid", 32'(rsp_valid), 0);
    chk("after_gnt", 32'(gnt), 0);
    chk("after_busy", 32'(busy), 0);
    chk_rsp("after_hold");
  endtask

  initial begin
    int ra;
    logic [1:0] r;
    rst = 1'b1; req = '0; lin_done = 1'b1; lin_y = '0;
    last_id = 0; last_data = '0; last_cyc = 0; last_to = 1'b0;
    tick(); tick();
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_start", 32'(lin_start), 0);
    chk("reset_valid", 32'(rsp_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk_rsp("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gen(0, 3 + i, 0);
      op(2'b11, -1);
    end
    gen(0, 5, 0); yv[5] = 4'h9;
    op(2'b01, -1);
    idle(2);
    gen(0, 30, 0);
    op(2'b10, -1);
    gen(1, 1, 30);
    op(2'b01, -1);
    gen(1, 3, 4);
    op(2'b01, -1);
    gen(0, 16, 0);
    op(2'b10, -1);
    gen(0, 30, 0);
    op(2'b01, 3);
    gen(0, 4, 0);
    op(2'b11, -1);
    for (int i = 0; i < 200; i++) begin
      r = 2'($urandom);
      if (r == 2'b00) idle(1);
      else begin
        gen(int'($urandom_range(2, 0)), int'($urandom_range(20, 1)), int'($urandom_range(22, 1)));
        ra = ($urandom_range(9, 0) == 0) ? int'($urandom_range(12, 0)) : -1;
        op(r, ra);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
